// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: pointer-width helper, default occupancy type and
// default almost-full/almost-empty thresholds used by the sync and async FIFOs.
package fifo_pkg;

  localparam int DEF_ADDRSIZE      = 7;
  localparam int DEF_AEMPTY_THRESH = 4;
  // Almost-full default sits this many words below DEPTH.
  localparam int DEF_AFULL_MARGIN  = 4;

  function automatic int ptr_w(input int addrsize);
    return addrsize + 1;
  endfunction

  typedef logic [DEF_ADDRSIZE:0] occ_t;

endpackage

// File: rtl/fifo_ram_sync.sv
// DEPTH x DATASIZE storage with a gated write port and a registered, gated
// read port, both on wclk. Only the read register is reset.
module fifo_ram_sync #(
  parameter int DATASIZE = 64,
  parameter int ADDRSIZE = 7
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                we,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                re,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [DATASIZE-1:0] rdata
);

  localparam int DEPTH = 1 << ADDRSIZE;

  logic [DATASIZE-1:0] r_mem [DEPTH];
  logic [DATASIZE-1:0] r_rdata;

  always_ff @(posedge wclk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n)  r_rdata <= '0;
    else if (re)  r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read, occupancy count and almost flags.
// Define SYNC_FIFO_ERR_EN to build the sticky overflow/underflow registers.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATASIZE      = 64,
  parameter int ADDRSIZE      = 7,
  parameter int AFULL_THRESH  = (1 << ADDRSIZE) - DEF_AFULL_MARGIN,
  parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                w_en,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                r_en,
  output logic [DATASIZE-1:0] rdata,
  output logic                rvalid,
  output logic                wfull,
  output logic                rempty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow
);

  localparam int PW = ptr_w(ADDRSIZE);
  localparam logic [PW-1:0] AF_T = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AE_T = PW'(AEMPTY_THRESH);

  logic [PW-1:0] r_wptr, r_rptr;
  logic [PW-1:0] w_count;
  logic          w_we, w_re;
  logic          r_rvalid;

  // Flags derive only from registered pointers; MSB is the wrap bit.
  assign w_count      = r_wptr - r_rptr;
  assign rempty       = (r_wptr == r_rptr);
  assign wfull        = (r_wptr[PW-1] != r_rptr[PW-1]) &&
                        (r_wptr[ADDRSIZE-1:0] == r_rptr[ADDRSIZE-1:0]);
  assign almost_full  = (w_count >= AF_T);
  assign almost_empty = (w_count <= AE_T);
  assign count        = w_count;

  assign w_we = w_en && !wfull;
  assign w_re = r_en && !rempty;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_rvalid <= 1'b0;
    end else begin
      if (w_we) r_wptr <= r_wptr + 1'b1;
      if (w_re) r_rptr <= r_rptr + 1'b1;
      r_rvalid <= w_re;
    end
  end

  assign rvalid = r_rvalid;

  fifo_ram_sync #(
    .DATASIZE (DATASIZE),
    .ADDRSIZE (ADDRSIZE)
  ) u_ram (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .we     (w_we),
    .waddr  (r_wptr[ADDRSIZE-1:0]),
    .wdata  (wdata),
    .re     (w_re),
    .raddr  (r_rptr[ADDRSIZE-1:0]),
    .rdata  (rdata)
  );

`ifdef SYNC_FIFO_ERR_EN
  logic r_overflow, r_underflow;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_en && wfull)  r_overflow  <= 1'b1;
      if (r_en && rempty) r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo at DATASIZE=8, ADDRSIZE=2, thresholds 3/1.
module tb_sync_fifo;

`ifdef SYNC_FIFO_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic       w_en, r_en;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rvalid, wfull, rempty, almost_full, almost_empty;
  logic [2:0] count;
  logic       overflow, underflow;

  int n_tests = 0;
  int n_fail  = 0;

  sync_fifo #(
    .DATASIZE      (8),
    .ADDRSIZE      (2),
    .AFULL_THRESH  (3),
    .AEMPTY_THRESH (1)
  ) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .w_en         (w_en),
    .wdata        (wdata),
    .r_en         (r_en),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .wfull        (wfull),
    .rempty       (rempty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 wclk = ~wclk;

  // Inputs change on the falling edge; the DUT samples them on the next
  // rising edge and results are observed on the following falling edge.
  task automatic cyc(input logic we, input logic re, input logic [7:0] d);
    w_en  = we;
    r_en  = re;
    wdata = d;
    @(negedge wclk);
    w_en  = 1'b0;
    r_en  = 1'b0;
  endtask

  task automatic test_reset;
    wrst_n = 1'b0; w_en = 1'b0; r_en = 1'b0; wdata = 8'h00;
    repeat (2) @(negedge wclk);
    wrst_n = 1'b1;
    @(negedge wclk);
    cyc(1'b1, 1'b0, 8'h77);
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b1, 1'b0, 8'h78);
    n_tests++;
    if (rdata !== 8'h77) begin
      n_fail++; $display("FAIL pre_reset_rdata got %h exp %h", rdata, 8'h77);
    end
    #2 wrst_n = 1'b0;
    #1;
    n_tests++;
    if (count !== 3'd0 || rdata !== 8'h00) begin
      n_fail++; $display("FAIL async_reset got count=%0d rdata=%h exp 0/00", count, rdata);
    end
    @(negedge wclk);
    wrst_n = 1'b1;
    @(negedge wclk);
    n_tests++;
    if ({rempty, wfull, almost_empty, almost_full, rvalid} !== 5'b10100) begin
      n_fail++; $display("FAIL reset_flags got e/f/ae/af/v=%b exp 10100",
                         {rempty, wfull, almost_empty, almost_full, rvalid});
    end
    n_tests++;
    if (count !== 3'd0 || rdata !== 8'h00 || overflow !== 1'b0 || underflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_state got count=%0d rdata=%h ov=%b un=%b exp 0/00/0/0",
                         count, rdata, overflow, underflow);
    end
  endtask

  task automatic test_fill;
    logic [7:0] pat [4];
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, pat[i]);
      n_tests++;
      if (count !== 3'(i + 1) || almost_full !== (i >= 2) || wfull !== (i == 3) ||
          almost_empty !== (i == 0) || rempty !== 1'b0) begin
        n_fail++; $display("FAIL fill_%0d got count=%0d af=%b full=%b ae=%b exp %0d/%b/%b/%b",
                           i, count, almost_full, wfull, almost_empty,
                           i + 1, (i >= 2), (i == 3), (i == 0));
      end
    end
    cyc(1'b1, 1'b0, 8'h55);
    n_tests++;
    if (count !== 3'd4 || wfull !== 1'b1 || overflow !== ERR) begin
      n_fail++; $display("FAIL overflow got count=%0d full=%b ov=%b exp 4/1/%b",
                         count, wfull, overflow, ERR);
    end
  endtask

  task automatic test_drain;
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      n_tests++;
      if (rdata !== exp_d[i] || rvalid !== 1'b1 || count !== 3'(3 - i)) begin
        n_fail++; $display("FAIL drain_%0d got rdata=%h v=%b count=%0d exp %h/1/%0d",
                           i, rdata, rvalid, count, exp_d[i], 3 - i);
      end
    end
    n_tests++;
    if (rempty !== 1'b1) begin
      n_fail++; $display("FAIL drain_empty got %b exp 1", rempty);
    end
    cyc(1'b0, 1'b1, 8'h00);
    n_tests++;
    if (rvalid !== 1'b0 || underflow !== ERR || rdata !== 8'h44 || count !== 3'd0) begin
      n_fail++; $display("FAIL underflow got v=%b un=%b rdata=%h count=%0d exp 0/%b/44/0",
                         rvalid, underflow, rdata, count, ERR);
    end
  endtask

  task automatic test_full_rw;
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'h61 + 8'(i));
    n_tests++;
    if (wfull !== 1'b1) begin
      n_fail++; $display("FAIL full_rw_setup got full=%b exp 1", wfull);
    end
    cyc(1'b1, 1'b1, 8'hEE);
    n_tests++;
    if (count !== 3'd3 || rdata !== 8'h61 || rvalid !== 1'b1) begin
      n_fail++; $display("FAIL full_rw got count=%0d rdata=%h v=%b exp 3/61/1",
                         count, rdata, rvalid);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      n_tests++;
      if (rdata !== 8'h62 + 8'(i) || rvalid !== 1'b1) begin
        n_fail++; $display("FAIL full_rw_drain_%0d got rdata=%h v=%b exp %h/1",
                           i, rdata, rvalid, 8'h62 + 8'(i));
      end
    end
    n_tests++;
    if (rempty !== 1'b1 || count !== 3'd0) begin
      n_fail++; $display("FAIL full_rw_end got empty=%b count=%0d exp 1/0", rempty, count);
    end
  endtask

  task automatic test_empty_rw;
    cyc(1'b1, 1'b1, 8'hA5);
    n_tests++;
    if (count !== 3'd1 || rvalid !== 1'b0 || almost_empty !== 1'b1) begin
      n_fail++; $display("FAIL empty_rw got count=%0d v=%b ae=%b exp 1/0/1",
                         count, rvalid, almost_empty);
    end
    cyc(1'b0, 1'b1, 8'h00);
    n_tests++;
    if (rdata !== 8'hA5 || rvalid !== 1'b1 || rempty !== 1'b1) begin
      n_fail++; $display("FAIL empty_rw_read got rdata=%h v=%b empty=%b exp a5/1/1",
                         rdata, rvalid, rempty);
    end
  endtask

  task automatic test_back_to_back;
    cyc(1'b1, 1'b0, 8'h80);
    cyc(1'b1, 1'b0, 8'h81);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, 8'h82 + 8'(i));
      n_tests++;
      if (count !== 3'd2 || rdata !== 8'h80 + 8'(i) || rvalid !== 1'b1 ||
          almost_empty !== 1'b0) begin
        n_fail++; $display("FAIL wrap_%0d got count=%0d rdata=%h v=%b ae=%b exp 2/%h/1/0",
                           i, count, rdata, rvalid, almost_empty, 8'h80 + 8'(i));
      end
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      n_tests++;
      if (rdata !== 8'h8A + 8'(i) || rvalid !== 1'b1) begin
        n_fail++; $display("FAIL wrap_drain_%0d got rdata=%h v=%b exp %h/1",
                           i, rdata, rvalid, 8'h8A + 8'(i));
      end
    end
    @(negedge wclk);
    n_tests++;
    if (rvalid !== 1'b0 || rdata !== 8'h8B || rempty !== 1'b1) begin
      n_fail++; $display("FAIL idle_hold got v=%b rdata=%h empty=%b exp 0/8b/1",
                         rvalid, rdata, rempty);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_full_rw();
    test_empty_rw();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
